// File: rtl/nano_mem_responder_if.sv
// rtl/nano_mem_responder_if.sv - NanoCPU memory bus and host load/dump port bundle
interface nano_mem_responder_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          ce;
    logic          we;
    logic [AW-1:0] address;
    logic [DW-1:0] dataW;
    logic [DW-1:0] dataR;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          watch_hit;
    logic [DW-1:0] watch_data;
    logic [15:0]   wr_count;

    modport master (
        output ce, we, address, dataW, host_req, host_we, host_addr, host_wdata,
        input  dataR, host_rdata, host_ack, watch_hit, watch_data, wr_count
    );

    modport slave (
        input  ce, we, address, dataW, host_req, host_we, host_addr, host_wdata,
        output dataR, host_rdata, host_ack, watch_hit, watch_data, wr_count
    );
endinterface

// File: rtl/nano_mem_responder.sv
// rtl/nano_mem_responder.sv - NanoCPU RAM with host four-phase port and write watch monitor
module nano_mem_responder #(
    parameter int            AW         = 8,
    parameter int            DW         = 16,
    parameter logic [AW-1:0] WATCH_ADDR = 8'd10
) (
    input  logic                 ck,
    input  logic                 rst,
    nano_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    state_t        state;
    logic          we_l;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l;
    logic [DW-1:0] host_rdata_r;
    logic          host_ack_r;
    logic          watch_hit_r;
    logic [DW-1:0] watch_data_r;
    logic [15:0]   wr_count_r;

    logic cpu_wr;
    logic host_go;

    assign cpu_wr  = bus.ce && bus.we;
    // Host only touches the array on an edge where the CPU is idle, so the
    // two write ports are mutually exclusive by construction.
    assign host_go = (state == PEND) && !bus.ce;

    assign bus.dataR      = mem[bus.address];
    assign bus.host_rdata = host_rdata_r;
    assign bus.host_ack   = host_ack_r;
    assign bus.watch_hit  = watch_hit_r;
    assign bus.watch_data = watch_data_r;
    assign bus.wr_count   = wr_count_r;

    // Array is deliberately left out of reset so loaded programs survive it.
    always_ff @(posedge ck) begin
        if (cpu_wr) begin
            mem[bus.address] <= bus.dataW;
        end else if (host_go && we_l && !rst) begin
            mem[addr_l] <= wdata_l;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state        <= IDLE;
            we_l         <= 1'b0;
            addr_l       <= '0;
            wdata_l      <= '0;
            host_rdata_r <= '0;
            host_ack_r   <= 1'b0;
            watch_hit_r  <= 1'b0;
            watch_data_r <= '0;
            wr_count_r   <= '0;
        end else begin
            watch_hit_r <= cpu_wr && (bus.address == WATCH_ADDR);
            if (cpu_wr && (bus.address == WATCH_ADDR)) begin
                watch_data_r <= bus.dataW;
            end
            if (cpu_wr && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.host_req) begin
                        we_l    <= bus.host_we;
                        addr_l  <= bus.host_addr;
                        wdata_l <= bus.host_wdata;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (host_go) begin
                        if (!we_l) begin
                            host_rdata_r <= mem[addr_l];
                        end
                        host_ack_r <= 1'b1;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    if (!bus.host_req) begin
                        host_ack_r <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    host_ack_r <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
